// File: rtl/tmds_period_scheduler_if.sv
// Timing, packet-handshake and TMDS-control signals shared between the
// scheduler and its surroundings.
interface tmds_period_scheduler_if;
   logic        de;
   logic [12:0] cycles_to_de;
   logic        hsync;
   logic        vsync;
   logic        pkt_req;
   logic [4:0]  pkt_count;
   logic [2:0]  mode;
   logic [3:0]  ctl;
   logic [1:0]  sync;
   logic        pkt_ack;
   logic [4:0]  pkt_index;
   logic [4:0]  pkt_cycle;
   logic        sched_err;

   modport master (
      output de, cycles_to_de, hsync, vsync, pkt_req, pkt_count,
      input  mode, ctl, sync, pkt_ack, pkt_index, pkt_cycle, sched_err
   );

   modport slave (
      input  de, cycles_to_de, hsync, vsync, pkt_req, pkt_count,
      output mode, ctl, sync, pkt_ack, pkt_index, pkt_cycle, sched_err
   );
endinterface

// File: rtl/tmds_period_scheduler.sv
// HDMI period sequencer: picks the TMDS channel mode and CTL bits each pixel
// clock and grants data-island slots to a packet source.
module tmds_period_scheduler #(
   parameter int unsigned CTL_MIN_PRE = 4,
   parameter int unsigned MAX_PKTS    = 18
) (
   input logic                    clk,
   input logic                    reset_n,
   tmds_period_scheduler_if.slave bus
);
   localparam logic [2:0] StCtrl      = 3'd0;
   localparam logic [2:0] StVidPre    = 3'd1;
   localparam logic [2:0] StVidGb     = 3'd2;
   localparam logic [2:0] StVidData   = 3'd3;
   localparam logic [2:0] StDiPre     = 3'd4;
   localparam logic [2:0] StDiGbLead  = 3'd5;
   localparam logic [2:0] StDiData    = 3'd6;
   localparam logic [2:0] StDiGbTrail = 3'd7;

   logic [2:0]  mode_q, mode_d;
   logic [2:0]  phase_q, phase_d;
   logic [3:0]  ctl_cnt_q, ctl_cnt_d;
   logic [3:0]  ctl_q, ctl_d;
   logic [4:0]  n_q, n_d;
   logic [4:0]  idx_q, idx_d;
   logic [4:0]  cyc_q, cyc_d;
   logic [1:0]  sync_q;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [4:0]  neff;
   logic [13:0] need;
   logic        grant;
   logic        busy;

   always_comb begin
      neff  = (bus.pkt_count > 5'(MAX_PKTS)) ? 5'(MAX_PKTS) : bus.pkt_count;
      // Island length plus the 14 cycles that keep a CTRL gap before the video preamble.
      need  = 14'd26 + {4'd0, neff, 5'd0};
      grant = bus.pkt_req && (bus.pkt_count != 5'd0) &&
              (32'(ctl_cnt_q) >= CTL_MIN_PRE) && ({1'b0, bus.cycles_to_de} >= need);
      busy  = (mode_q != StCtrl) && (mode_q != StVidData);
   end

   always_comb begin
      mode_d = mode_q;
      n_d    = n_q;
      idx_d  = idx_q;
      cyc_d  = cyc_q;
      ack_d  = 1'b0;
      err_d  = 1'b0;

      if (bus.de && !(mode_q == StVidData || (mode_q == StVidGb && phase_q == 3'd1))) begin
         err_d  = 1'b1;
         mode_d = StVidData;
      end else begin
         if (busy && bus.cycles_to_de == 13'd10) err_d = 1'b1;
         case (mode_q)
            StCtrl: begin
               if (bus.cycles_to_de == 13'd10) begin
                  mode_d = StVidPre;
               end else if (grant) begin
                  mode_d = StDiPre;
                  ack_d  = 1'b1;
                  n_d    = neff;
               end
            end
            StVidPre:    if (phase_q == 3'd7) mode_d = StVidGb;
            StVidGb:     if (phase_q == 3'd1) mode_d = StVidData;
            StVidData:   if (!bus.de) mode_d = StCtrl;
            StDiPre:     if (phase_q == 3'd7) mode_d = StDiGbLead;
            StDiGbLead:  if (phase_q == 3'd1) mode_d = StDiData;
            StDiData: begin
               if (cyc_q == 5'd31) begin
                  cyc_d = 5'd0;
                  if (idx_q == n_q - 5'd1) mode_d = StDiGbTrail;
                  else                     idx_d  = idx_q + 5'd1;
               end else begin
                  cyc_d = cyc_q + 5'd1;
               end
            end
            StDiGbTrail: if (phase_q == 3'd1) mode_d = StCtrl;
            default:     mode_d = StCtrl;
         endcase
      end

      if (mode_d != StDiData || mode_q != StDiData) begin
         idx_d = (mode_d == StDiData && mode_q == StDiData) ? idx_d : 5'd0;
         cyc_d = (mode_d == StDiData && mode_q == StDiData) ? cyc_d : 5'd0;
      end

      phase_d = (mode_d != mode_q) ? 3'd0 : phase_q + 3'd1;

      if (mode_d == StCtrl) begin
         if (mode_q != StCtrl)            ctl_cnt_d = 4'd0;
         else if (ctl_cnt_q != 4'hf)      ctl_cnt_d = ctl_cnt_q + 4'd1;
         else                             ctl_cnt_d = ctl_cnt_q;
      end else begin
         ctl_cnt_d = ctl_cnt_q;
      end

      if (mode_d == StVidPre)     ctl_d = 4'b0001;
      else if (mode_d == StDiPre) ctl_d = 4'b0101;
      else                        ctl_d = 4'b0000;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q    <= StCtrl;
         phase_q   <= 3'd0;
         ctl_cnt_q <= 4'd0;
         ctl_q     <= 4'd0;
         n_q       <= 5'd0;
         idx_q     <= 5'd0;
         cyc_q     <= 5'd0;
         sync_q    <= 2'd0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         phase_q   <= phase_d;
         ctl_cnt_q <= ctl_cnt_d;
         ctl_q     <= ctl_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         cyc_q     <= cyc_d;
         sync_q    <= {bus.vsync, bus.hsync};
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   assign bus.mode      = mode_q;
   assign bus.ctl       = ctl_q;
   assign bus.sync      = sync_q;
   assign bus.pkt_ack   = ack_q;
   assign bus.pkt_index = idx_q;
   assign bus.pkt_cycle = cyc_q;
   assign bus.sched_err = err_q;
endmodule

// File: doc/tmds_period_scheduler.md
# tmds_period_scheduler

Sequences the HDMI period structure (control, video preamble/guard/data, data-island preamble/guard/data) that drives the per-channel TMDS encoders. It sits between the video timing generator and the three TMDS channel instances. It decides cycle by cycle which operating mode the channels run and which CTL/sync bits they carry, and it grants data-island slots to a packet source through a request/acknowledge handshake.

## Interface
- `CTL_MIN_PRE`, default 4: minimum plain control cycles required before any preamble.
- `MAX_PKTS`, default 18: maximum packets per data island. `pkt_count` values above this are clamped.
- `clk` in 1: pixel clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `de` in 1: active-video flag from the timing generator.
- `cycles_to_de` in 13: when `de`=0, the number of edges until `de` is sampled 1. Don't-care when `de`=1.
- `hsync`, `vsync` in 1 each.
- `pkt_req` in 1: packet source has an island pending. Level signal, held until acked.
- `pkt_count` in 5: number of packets N in the pending island. 0 means no request.
- `mode` out 3: 0 CTRL, 1 VID_PRE, 2 VID_GB, 3 VID_DATA, 4 DI_PRE, 5 DI_GB_LEAD, 6 DI_DATA, 7 DI_GB_TRAIL.
- `ctl` out 4: {CTL3,CTL2,CTL1,CTL0} for channels 1/2.
- `sync` out 2: {vsync,hsync}, registered.
- `pkt_ack` out 1: one-cycle pulse when an island is granted.
- `pkt_index` out 5: packet number within the island. 0 outside DI_DATA.
- `pkt_cycle` out 5: character index 0..31 within the packet. 0 outside DI_DATA.
- `sched_err` out 1: one-cycle pulse on a schedule violation.

## Operation
- All outputs are registered. Every decision uses inputs sampled at edge k and appears after edge k.
- `ctl_cnt`: 4-bit saturating counter. Cleared on entry to CTRL, increments each cycle in CTRL.
- `Neff` = min(`pkt_count`, MAX_PKTS).
- Island length L = 12 + 32·Neff.
- CTRL:
  - `de`=1 → VID_DATA and `sched_err` pulse (missed preamble).
  - Else if `cycles_to_de`==10 → VID_PRE, regardless of `ctl_cnt`.
  - Else if `pkt_req` and `pkt_count`≠0 and `ctl_cnt`≥CTL_MIN_PRE and `cycles_to_de`≥L+14 → DI_PRE. In this case `pkt_ack`=1 and Neff is latched.
  - Otherwise stay in CTRL.
- VID_PRE lasts 8 cycles, then VID_GB. VID_GB lasts 2 cycles, then VID_DATA.
- VID_DATA stays while `de`=1. `de`=0 → CTRL.
- DI_PRE lasts 8 cycles, then DI_GB_LEAD for 2 cycles, then DI_DATA.
- DI_DATA lasts 32·N cycles. `pkt_cycle` counts 0..31, and `pkt_index` increments on each `pkt_cycle` wrap. It exits after `pkt_index`=N-1, `pkt_cycle`=31, then DI_GB_TRAIL for 2 cycles, then CTRL.
- `ctl` values:
  - 4'b0001 in VID_PRE.
  - 4'b0101 in DI_PRE.
  - 4'b0000 in all other states.
- `sync` = registered {vsync,hsync} in every state.
- Violations:
  - `de`=1 sampled in any state other than VID_GB (last cycle) or VID_DATA → VID_DATA, `sched_err`. An in-flight island is abandoned.
  - `cycles_to_de`==10 sampled while an island or a video preamble is in progress → `sched_err` only; the sequence continues.
- `pkt_req` changes while an island is running are ignored. N stays latched.

## Timing
- Reset values: `mode`=0, `ctl`=0, `sync`=0, `pkt_ack`=0, `pkt_index`=0, `pkt_cycle`=0, `sched_err`=0, `ctl_cnt`=0. Reset may assert mid-island; no pending state survives.
- Latency: one cycle from input sample to outputs.
- Video alignment: `cycles_to_de`==10 at edge k gives VID_PRE after edges k..k+7, VID_GB after k+8..k+9, and VID_DATA after k+10, the edge where `de` is sampled 1.
- Island spacing: an island granted at edge k with `cycles_to_de`=M occupies k..k+L−1, followed by ≥4 CTRL cycles before VID_PRE. This holds because M ≥ L+14.
- Handshake: `pkt_ack` rises in the same cycle that `mode` becomes DI_PRE. The source must drop or refresh `pkt_req` the following cycle. Back-to-back islands require a new `ctl_cnt`≥CTL_MIN_PRE interval.
- `pkt_cycle`/`pkt_index` wrap correctly at N=18, the last packet index being 17.

## Test plan
- Reset, then `de`=0 with `cycles_to_de` counting 40→0 and no request → CTRL until `cycles_to_de`==10, then 8×VID_PRE (`ctl`=0001), 2×VID_GB, VID_DATA on the `de`=1 edge.
- `pkt_req`=1, `pkt_count`=1, `cycles_to_de`=100, `ctl_cnt`≥4 → `pkt_ack` pulse, 8 DI_PRE (`ctl`=0101), 2 DI_GB_LEAD, 32 DI_DATA with `pkt_cycle` 0..31, 2 DI_GB_TRAIL, CTRL.
- `pkt_count`=2, `cycles_to_de`=89 (L+14=90) → no grant. `cycles_to_de`=90 → grant, island of 76 cycles, then exactly 4 CTRL cycles before VID_PRE.
- `pkt_count`=25 → clamped to 18: 576 DI_DATA cycles, `pkt_index` reaches 17.
- `de` forced to 1 during DI_DATA → next cycle `mode`=VID_DATA, `sched_err`=1 for one cycle.
- `reset_n` asserted low mid-DI_DATA → all outputs return to reset values immediately; after release, `mode`=CTRL and `ctl_cnt` restarts from 0.
